// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite job master: response codes, FSM
// state encoding and default register map / job handshake values.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] DEF_ADDR_START  = 32'h0000_1000;
    localparam logic [31:0] DEF_ADDR_STATUS = 32'h0000_2000;
    localparam logic [31:0] DEF_START_VALUE = 32'h0000_0001;
    localparam logic [31:0] DEF_DONE_VALUE  = 32'h0000_0002;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_GAP
    } job_state_e;

    function automatic logic resp_is_okay(input logic [1:0] resp);
        return resp == RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_single_beat_wr.sv
// Single-beat AXI-Lite write engine: issues one AW and one W beat that may
// complete in any order, then accepts the B response. All bus outputs are
// registered; b_fire/b_resp expose the response handshake to the owner.
module axil_single_beat_wr #(
    parameter int unsigned          AW      = 32,
    parameter int unsigned          DW      = 32,
    parameter logic [AW-1:0]        WR_ADDR = '0,
    parameter logic [DW-1:0]        WR_DATA = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            b_phase,
    output logic            b_fire,
    output logic [1:0]      b_resp,
    output logic [AW-1:0]   m_axil_awaddr,
    output logic            m_axil_awvalid,
    input  logic            m_axil_awready,
    output logic [DW-1:0]   m_axil_wdata,
    output logic [DW/8-1:0] m_axil_wstrb,
    output logic            m_axil_wvalid,
    input  logic            m_axil_wready,
    input  logic [1:0]      m_axil_bresp,
    input  logic            m_axil_bvalid,
    output logic            m_axil_bready
);
    import axil_pkg::*;

    logic          awvalid_q, awvalid_d;
    logic          wvalid_q,  wvalid_d;
    logic          bready_q,  bready_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q,  w_done_d;
    logic          active_q,  active_d;
    logic [AW-1:0] awaddr_q,  awaddr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          aw_fire, w_fire;

    // Next-state: AW and W retire independently; B opens once both have retired.
    always_comb begin
        aw_fire   = awvalid_q & m_axil_awready;
        w_fire    = wvalid_q & m_axil_wready;
        b_fire    = bready_q & m_axil_bvalid;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        active_d  = active_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        if (start) begin
            active_d  = 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awaddr_d  = WR_ADDR;
            wdata_d   = WR_DATA;
        end else begin
            if (aw_fire) begin
                awvalid_d = 1'b0;
                aw_done_d = 1'b1;
            end
            if (w_fire) begin
                wvalid_d = 1'b0;
                w_done_d = 1'b1;
            end
            // A handshake retiring this cycle counts as done so B opens one cycle sooner.
            if (active_q && (aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                active_d = 1'b0;
                bready_d = 1'b1;
            end
            if (b_fire) begin
                bready_d = 1'b0;
            end
        end
    end

    // State and bus output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            active_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            active_q  <= active_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign b_phase        = bready_q;
    assign b_resp         = m_axil_bresp;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;

endmodule

// File: rtl/axil_job_master.sv
// AXI-Lite job master: writes START_VALUE to ADDR_START, then polls
// ADDR_STATUS until it reads DONE_VALUE, reporting job_done / job_error.
// Optional: define AXIL_POLL_TIMEOUT_EN to bound polling to MAX_POLLS reads.
module axil_job_master #(
    parameter int unsigned           AXIL_AW     = 32,
    parameter int unsigned           AXIL_DW     = 32,
    parameter logic [AXIL_AW-1:0]    ADDR_START  = AXIL_AW'(axil_pkg::DEF_ADDR_START),
    parameter logic [AXIL_AW-1:0]    ADDR_STATUS = AXIL_AW'(axil_pkg::DEF_ADDR_STATUS),
    parameter logic [AXIL_DW-1:0]    START_VALUE = AXIL_DW'(axil_pkg::DEF_START_VALUE),
    parameter logic [AXIL_DW-1:0]    DONE_VALUE  = AXIL_DW'(axil_pkg::DEF_DONE_VALUE),
    parameter int unsigned           POLL_GAP    = 4
`ifdef AXIL_POLL_TIMEOUT_EN
    ,
    parameter int unsigned           MAX_POLLS   = 1024
`endif
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    input  logic                 job_start,
    output logic                 busy,
    output logic                 job_done,
    output logic                 job_error,
    output logic [AXIL_DW-1:0]   last_status,
    output logic [AXIL_AW-1:0]   m_axil_awaddr,
    output logic                 m_axil_awvalid,
    input  logic                 m_axil_awready,
    output logic [AXIL_DW-1:0]   m_axil_wdata,
    output logic [AXIL_DW/8-1:0] m_axil_wstrb,
    output logic                 m_axil_wvalid,
    input  logic                 m_axil_wready,
    input  logic [1:0]           m_axil_bresp,
    input  logic                 m_axil_bvalid,
    output logic                 m_axil_bready,
    output logic [AXIL_AW-1:0]   m_axil_araddr,
    output logic                 m_axil_arvalid,
    input  logic                 m_axil_arready,
    input  logic [AXIL_DW-1:0]   m_axil_rdata,
    input  logic [1:0]           m_axil_rresp,
    input  logic                 m_axil_rvalid,
    output logic                 m_axil_rready
);
    import axil_pkg::*;

    job_state_e          state_q, state_d;
    logic                busy_q, busy_d;
    logic                job_done_q, job_done_d;
    logic                job_error_q, job_error_d;
    logic [AXIL_DW-1:0]  last_status_q, last_status_d;
    logic                arvalid_q, arvalid_d;
    logic [AXIL_AW-1:0]  araddr_q, araddr_d;
    logic                rready_q, rready_d;
    logic [31:0]         gap_cnt_q, gap_cnt_d;
`ifdef AXIL_POLL_TIMEOUT_EN
    logic [31:0]         poll_cnt_q, poll_cnt_d;
`endif

    logic                wr_start;
    logic                wr_b_phase;
    logic                wr_b_fire;
    logic [1:0]          wr_b_resp;

    axil_single_beat_wr #(
        .AW      (AXIL_AW),
        .DW      (AXIL_DW),
        .WR_ADDR (ADDR_START),
        .WR_DATA (START_VALUE)
    ) u_wr (
        .clk            (user_clk),
        .rst            (user_reset),
        .start          (wr_start),
        .b_phase        (wr_b_phase),
        .b_fire         (wr_b_fire),
        .b_resp         (wr_b_resp),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    // Job sequencing: start write, status polling with gap, completion pulses.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        job_done_d    = 1'b0;
        job_error_d   = 1'b0;
        last_status_d = last_status_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        rready_d      = rready_q;
        gap_cnt_d     = gap_cnt_q;
        wr_start      = 1'b0;
`ifdef AXIL_POLL_TIMEOUT_EN
        poll_cnt_d    = poll_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (job_start) begin
                    wr_start = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_WR;
`ifdef AXIL_POLL_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end
            // B can fire before the FSM has moved to WRESP, so both states accept it.
            ST_WR, ST_WRESP: begin
                if (wr_b_fire) begin
                    if (resp_is_okay(wr_b_resp)) begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = ADDR_STATUS;
                    end else begin
                        job_error_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else if (state_q == ST_WR && wr_b_phase) begin
                    state_d = ST_WRESP;
                end
            end
            ST_RD_ADDR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axil_rvalid) begin
                    rready_d      = 1'b0;
                    last_status_d = m_axil_rdata;
`ifdef AXIL_POLL_TIMEOUT_EN
                    poll_cnt_d    = poll_cnt_q + 32'd1;
`endif
                    if (!resp_is_okay(m_axil_rresp)) begin
                        job_error_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (m_axil_rdata == DONE_VALUE) begin
                        job_done_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end
`ifdef AXIL_POLL_TIMEOUT_EN
                    else if (poll_cnt_q == MAX_POLLS - 32'd1) begin
                        job_error_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end
`endif
                    else if (POLL_GAP == 0) begin
                        arvalid_d = 1'b1;
                        araddr_d  = ADDR_STATUS;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == POLL_GAP - 32'd1) begin
                    arvalid_d = 1'b1;
                    araddr_d  = ADDR_STATUS;
                    state_d   = ST_RD_ADDR;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            job_error_q   <= 1'b0;
            last_status_q <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            rready_q      <= 1'b0;
            gap_cnt_q     <= '0;
`ifdef AXIL_POLL_TIMEOUT_EN
            poll_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            job_done_q    <= job_done_d;
            job_error_q   <= job_error_d;
            last_status_q <= last_status_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            rready_q      <= rready_d;
            gap_cnt_q     <= gap_cnt_d;
`ifdef AXIL_POLL_TIMEOUT_EN
            poll_cnt_q    <= poll_cnt_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign job_done       = job_done_q;
    assign job_error      = job_error_q;
    assign last_status    = last_status_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: doc/axil_job_master.md
Name: axil_job_master

Overview:
- AXI-Lite initiator that launches one accelerator job on the Usr_Logic slave and polls it to completion, replacing host/bench-driven register pokes.
- On a start pulse it writes START_VALUE to ADDR_START.
- It then repeatedly reads ADDR_STATUS until the read data equals DONE_VALUE, and reports done or error to local control logic.
- It sits between an on-chip controller and the s_axil_* port of Usr_Logic.

Parameters:
- AXIL_AW, 32, address width
- AXIL_DW, 32, data width
- ADDR_START, 32'h0000_1000, start register address
- ADDR_STATUS, 32'h0000_2000, status register address
- START_VALUE, 32'h1, data written to start the job
- DONE_VALUE, 32'h2, status value meaning job complete
- POLL_GAP, 4, idle cycles between status reads (0 allowed)

Ports:
- user_clk  in  1  clock
- user_reset  in  1  synchronous active-high reset
- job_start  in  1  one-cycle pulse; ignored unless busy=0
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse on DONE_VALUE seen
- job_error  out  1  one-cycle pulse on error response (or timeout)
- last_status  out  AXIL_DW  last read status data
- m_axil_awaddr  out  AXIL_AW  write address
- m_axil_awvalid  out  1  write address valid
- m_axil_awready  in  1  write address ready
- m_axil_wdata  out  AXIL_DW  write data
- m_axil_wstrb  out  AXIL_DW/8  write strobes, all ones
- m_axil_wvalid  out  1  write data valid
- m_axil_wready  in  1  write data ready
- m_axil_bresp  in  2  write response
- m_axil_bvalid  in  1  write response valid
- m_axil_bready  out  1  write response ready
- m_axil_araddr  out  AXIL_AW  read address
- m_axil_arvalid  out  1  read address valid
- m_axil_arready  in  1  read address ready
- m_axil_rdata  in  AXIL_DW  read data
- m_axil_rresp  in  2  read response
- m_axil_rvalid  in  1  read data valid
- m_axil_rready  out  1  read data ready

Behaviour:
- Clock and reset: single clock user_clk; reset user_reset is synchronous, active-high.
- Reset values: all valid/ready outputs, busy, job_done and job_error are 0; last_status is 0; FSM is IDLE. Reset mid-transaction drops all valids immediately; no completion is owed.
- Registered outputs: all outputs are registered. Address and data outputs are constant within a transaction.
- IDLE: on job_start, go to WR, set busy=1, and assert awvalid and wvalid on the next cycle, with awaddr=ADDR_START and wdata=START_VALUE.
- WR:
  - awvalid stays high until the cycle after awvalid&awready; wvalid likewise with wready, independently.
  - AW and W may complete in the same cycle or in either order.
  - Once both handshakes are done, go to WRESP.
- WRESP: bready=1. On bvalid:
  - bresp==2'b00 -> RD_ADDR.
  - otherwise pulse job_error -> IDLE.
- RD_ADDR: arvalid=1, araddr=ADDR_STATUS. On arready -> RD_DATA, arvalid low the next cycle.
- RD_DATA: rready=1. On rvalid, capture last_status<=rdata, then:
  - rresp!=OKAY -> job_error pulse, IDLE.
  - else rdata==DONE_VALUE -> job_done pulse, IDLE.
  - else -> GAP.
- GAP: count POLL_GAP cycles, then RD_ADDR. When POLL_GAP=0, go directly to RD_ADDR.
- Job end: busy drops in the same cycle as the job_done or job_error pulse.
- Valid stability: a valid is never deasserted before its handshake.
- Outstanding transactions: only one outstanding transaction at a time.
- job_start while busy: ignored, no queuing.
- job_start with a simultaneous reset: reset wins.

Optional Feature:
- AXIL_POLL_TIMEOUT_EN defined:
  - adds parameter MAX_POLLS (default 1024) and a poll counter cleared at job start.
  - if the MAX_POLLS-th read returns non-DONE (OKAY response), pulse job_error and go to IDLE.
- Undefined: polling is unbounded.

Decomposition:
- Shared package axil_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, FSM state enum, default register addresses and START/DONE values.
- One natural sub-module: axil_single_beat_wr, which handles independent AW/W completion plus B. The read path stays inline.

Test Plan:
- Ideal slave (ready always 1, status returns 2 on the first read) -> one write to 0x1000 with data 1, one read of 0x2000, job_done pulse, last_status=2, busy low 1 cycle after the rdata handshake.
- awready lags wready by 3 cycles -> wvalid drops after the W handshake while awvalid is held until the AW handshake; no duplicate beats.
- Status returns 0,1,1,2 with POLL_GAP=4 -> exactly 4 reads, at least 4 idle cycles between arvalid episodes, job_done once, last_status=2.
- bresp=2'b10 on the start write -> job_error pulse, no read issued, busy=0.
- user_reset asserted while in RD_DATA -> arvalid/rready/busy are 0 next cycle; a new job_start runs cleanly; job_start during busy is ignored.
- With AXIL_POLL_TIMEOUT_EN and MAX_POLLS=3, status stuck at 1 -> 3 reads then job_error, no job_done.
